radio_cnn_top: RTL and testbench
================================

# radio_cnn_top

Streaming ternary-weight classifier: top of the radio-modulation inference path. Consumes two lanes of I/Q samples per cycle, computes ReLU feature maps, and averages them over a fixed-length frame. A dense layer then emits 24 signed class scores, one score vector per frame.

## Interface
- FILTER_WIDTH, 128: packed feature-vector width in bits. Feature count NF = FILTER_WIDTH/8. Must be a multiple of 8.
- FRAME_LEN, 32: valid input cycles per frame. Must be a power of two, ≥2.
- W1, default below: layer-1 ternary weights, NF×4 entries, 2 bits each. Entry [f][j] is at bits (f*4+j)*2 +: 2. Default: w1[f][f mod 4] = +1, all others 0.
- W2, default below: layer-2 ternary weights, 24×NF entries, 2 bits each. Entry [k][f] is at bits (k*NF+f)*2 +: 2. Default: w2[k][k mod NF] = +1, all others 0.
- Ternary encoding: 2'b01 = +1, 2'b11 = −1, 2'b00/2'b10 = 0.
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- vld_in, in, 1: data_in holds a valid sample this cycle.
- data_in, in, [1:0][1:0][7:0]: lane l, component c, signed 8-bit. Flattened input x[2l+c].
- vld_out, out, 1: one-cycle pulse; data_out holds a new frame result.
- data_out, out, 24 × 10: signed class scores, element k = class k.

## Operation
- Stage 1, registered on each edge where vld_in=1:
  - s_f = Σ_j w1[f][j]·x[j], computed at 10-bit signed width.
  - feat_f = ReLU(s_f), saturated to 255, stored as 8-bit unsigned.
  - feat_vld is set for one cycle.
- Stage 2, accumulate on each edge where feat_vld=1:
  - acc_f += feat_f. Accumulator width is 8+log2(FRAME_LEN).
  - cnt increments; it wraps from FRAME_LEN−1 to 0.
- End of frame (feat_vld with cnt = FRAME_LEN−1):
  - mean_f ← (acc_f + feat_f) >> log2(FRAME_LEN), truncating.
  - acc_f is cleared to 0 in the same edge, so the next sample starts a fresh frame.
  - mean_vld is set for one cycle.
- Stage 3, on mean_vld:
  - y_k = Σ_f w2[k][f]·mean_f, computed at 8+log2(NF)+2 bits signed.
  - y_k is saturated to [−512, 511].
  - data_out[k] ← y_k; vld_out=1 for one cycle.
- data_out holds its value until the next frame result.
- Gaps in vld_in are allowed. A frame is FRAME_LEN valid samples, not FRAME_LEN cycles.
- No back-pressure. Every frame produces exactly one result.

## Timing
- Reset (rst=0, asynchronous): vld_out=0, all data_out=0, cnt=0, all acc=0, all feat/mean registers=0, all internal valids=0. A partial frame is discarded.
- Release: the first edge with rst=1 and vld_in=1 is sample 0 of a new frame.
- Latency: the last sample of a frame is captured at edge n. Then:
  - feat_vld is high after edge n.
  - mean_vld is high after edge n+1.
  - vld_out is high after edge n+2, for exactly one cycle.
  - data_out is updated at edge n+2.
- Back-to-back frames: full throughput with vld_in=1 continuously, giving one vld_out every FRAME_LEN cycles.
- The frame boundary, the accumulator clear, and a new valid sample can coincide on one edge. No sample is lost or double-counted.

## Test plan
All scenarios use default parameters (NF=16, FRAME_LEN=32).
- Reset hold: rst=0 for 5 cycles, vld_in toggling → vld_out=0, all data_out=0 throughout.
- Constant input: x = {2,0,1,0} (data_in[0]=16'h0002, data_in[1]=16'h0001), vld_in=1 for 32 cycles.
  - Response: one vld_out pulse 2 edges after the 32nd sample edge.
  - data_out[k] = 2, 0, 1, 0 for k mod 4 = 0, 1, 2, 3.
- ReLU: x = {8'hFB, 8'h80, 8'h05, 0} for 32 samples → data_out[k] = 0, 0, 5, 0 for k mod 4 = 0, 1, 2, 3.
- Ramp and truncation: x[0] = 0, 2, 4, …, 62 over 32 samples, other inputs 0.
  - Mean = 992/32 = 31.
  - data_out[k] = 31 for k mod 4 = 0, else 0.
- Gapped valid, continuous run:
  - 32 samples of the constant input with vld_in alternating 1/0 → exactly one pulse, values as in the constant-input case.
  - 9 back-to-back frames with vld_in=1 continuously → 9 pulses 32 cycles apart, identical values.
- Reset mid-frame: 20 samples of x = {100,100,100,100}, assert rst, then 32 samples of the constant input.
  - Response: one pulse with the constant-input values.
  - No contribution from the 100s.

Source files
------------

// File: rtl/radio_cnn_top.sv
`default_nettype none
// radio_cnn_top: streaming ternary-weight classifier; ReLU features, frame mean, dense layer to 24 scores.
// Revision: 1.0
module radio_cnn_top #(
    parameter int FILTER_WIDTH = 128,
    parameter int FRAME_LEN    = 32,
    parameter logic [FILTER_WIDTH-1:0] W1 = {(FILTER_WIDTH/32){32'h40100401}},
    // Default literal encodes w2[k][k mod 16] = +1 for the default 16-feature build.
    parameter logic [24*(FILTER_WIDTH/8)*2-1:0] W2 = {
        256'h00004000_00001000_00000400_00000100_00000040_00000010_00000004_00000001,
        256'h40000000_10000000_04000000_01000000_00400000_00100000_00040000_00010000,
        256'h00004000_00001000_00000400_00000100_00000040_00000010_00000004_00000001}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_in,
    input  logic [1:0][1:0][7:0] data_in,
    output logic                 vld_out,
    output logic [23:0][9:0]     data_out
);
    localparam int NF      = FILTER_WIDTH / 8;
    localparam int LOG2_FL = $clog2(FRAME_LEN);
    localparam int ACC_W   = 8 + LOG2_FL;
    localparam int Y_W     = 8 + $clog2(NF) + 2;
    localparam logic signed [Y_W-1:0] c_Y_MAX = Y_W'(511);
    localparam logic signed [Y_W-1:0] c_Y_MIN = Y_W'(-512);

    function automatic logic [9:0] f_tern10(input logic [1:0] w, input logic [9:0] v);
        case (w)
            2'b01:   f_tern10 = v;
            2'b11:   f_tern10 = -v;
            default: f_tern10 = '0;
        endcase
    endfunction

    function automatic logic [Y_W-1:0] f_terny(input logic [1:0] w, input logic [Y_W-1:0] v);
        case (w)
            2'b01:   f_terny = v;
            2'b11:   f_terny = -v;
            default: f_terny = '0;
        endcase
    endfunction

    logic [3:0][9:0]          w_x;
    logic [NF-1:0][9:0]       w_s;
    logic [NF-1:0][7:0]       w_feat;
    logic [NF-1:0][ACC_W-1:0] w_sum;
    logic [NF-1:0][7:0]       w_mean;
    logic [23:0][Y_W-1:0]     w_y;
    logic [23:0][9:0]         w_sat;
    logic                     w_frame_end;

    logic [NF-1:0][7:0]       r_feat;
    logic                     r_feat_vld;
    logic [NF-1:0][ACC_W-1:0] r_acc;
    logic [LOG2_FL-1:0]       r_cnt;
    logic [NF-1:0][7:0]       r_mean;
    logic                     r_mean_vld;
    logic                     r_vld_out;
    logic [23:0][9:0]         r_data_out;

    // Layer 1 wraps at 10 bits, then ReLU with saturation to 255.
    always_comb begin
        w_x    = '0;
        w_s    = '0;
        w_feat = '0;
        for (int j = 0; j < 4; j++) begin
            w_x[j] = {{2{data_in[j/2][j%2][7]}}, data_in[j/2][j%2]};
        end
        for (int f = 0; f < NF; f++) begin
            for (int j = 0; j < 4; j++) begin
                w_s[f] = w_s[f] + f_tern10(W1[(f*4+j)*2 +: 2], w_x[j]);
            end
            if (w_s[f][9]) begin
                w_feat[f] = 8'd0;
            end else if (w_s[f][8]) begin
                w_feat[f] = 8'hFF;
            end else begin
                w_feat[f] = w_s[f][7:0];
            end
        end
    end

    // The closing sample is folded in here so the accumulator can clear on the same edge.
    always_comb begin
        w_sum  = '0;
        w_mean = '0;
        for (int f = 0; f < NF; f++) begin
            w_sum[f]  = r_acc[f] + {{LOG2_FL{1'b0}}, r_feat[f]};
            w_mean[f] = w_sum[f][ACC_W-1:LOG2_FL];
        end
    end

    assign w_frame_end = (r_cnt == LOG2_FL'(FRAME_LEN - 1));

    always_comb begin
        w_y   = '0;
        w_sat = '0;
        for (int k = 0; k < 24; k++) begin
            for (int f = 0; f < NF; f++) begin
                w_y[k] = w_y[k] + f_terny(W2[(k*NF+f)*2 +: 2], {{(Y_W-8){1'b0}}, r_mean[f]});
            end
            if ($signed(w_y[k]) > c_Y_MAX) begin
                w_sat[k] = 10'h1FF;
            end else if ($signed(w_y[k]) < c_Y_MIN) begin
                w_sat[k] = 10'h200;
            end else begin
                w_sat[k] = w_y[k][9:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_feat     <= '0;
            r_feat_vld <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_mean     <= '0;
            r_mean_vld <= 1'b0;
            r_vld_out  <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_feat_vld <= vld_in;
            if (vld_in) begin
                r_feat <= w_feat;
            end
            r_mean_vld <= 1'b0;
            if (r_feat_vld) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_frame_end) begin
                    r_mean     <= w_mean;
                    r_acc      <= '0;
                    r_mean_vld <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                end
            end
            r_vld_out <= r_mean_vld;
            if (r_mean_vld) begin
                r_data_out <= w_sat;
            end
        end
    end

    assign vld_out  = r_vld_out;
    assign data_out = r_data_out;
endmodule
`default_nettype wire

// File: tb/tb_radio_cnn_top.sv
`default_nettype none
// tb_radio_cnn_top: directed frames with a scoreboard queue checked by an output monitor.
// Revision: 1.0
module tb_radio_cnn_top;
    typedef struct {
        logic [23:0][9:0] v;
        int               cyc;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 vld_in;
    logic [1:0][1:0][7:0] data_in;
    logic                 vld_out;
    logic [23:0][9:0]     data_out;

    exp_t             sb[$];
    int               cyc;
    int               total;
    int               bad;
    logic [23:0][9:0] last_exp;
    logic             end_chk;
    logic             end_done;

    radio_cnn_top dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .data_in  (data_in),
        .vld_out  (vld_out),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0][9:0] pat(input logic [9:0] a0, input logic [9:0] a1,
                                             input logic [9:0] a2, input logic [9:0] a3);
        logic [23:0][9:0] r;
        for (int k = 0; k < 24; k++) begin
            case (k % 4)
                0:       r[k] = a0;
                1:       r[k] = a1;
                2:       r[k] = a2;
                default: r[k] = a3;
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
        @(posedge clk);
        #1;
        vld_in        = v;
        data_in[0][0] = a0;
        data_in[0][1] = a1;
        data_in[1][0] = a2;
        data_in[1][1] = a3;
    endtask

    // Sample captured at the next edge; the result appears two edges after that.
    task automatic frame(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                         input logic [7:0] a3, input logic ramp, input logic gapped,
                         input logic [23:0][9:0] expv);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, ramp ? 8'(2*i) : a0, a1, a2, a3);
            if (i == 31) begin
                e.v   = expv;
                e.cyc = cyc + 3;
                sb.push_back(e);
            end
            if (gapped) drive(1'b0, a0, a1, a2, a3);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (vld_out !== 1'b0 || data_out !== '0) begin
                bad++;
                $display("FAIL reset_state: vld_out=%b data_out=%h, required 0", vld_out, data_out);
            end
            last_exp = '0;
        end else if (vld_out === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data_out !== e.v || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL frame_result: cycle %0d data %h, required cycle %0d data %h",
                             cyc, data_out, e.cyc, e.v);
                end
                last_exp = e.v;
            end
        end else begin
            total++;
            if (data_out !== last_exp) begin
                bad++;
                $display("FAIL hold: data_out=%h, required %h", data_out, last_exp);
            end
        end
        if (end_chk && !end_done) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL missing_pulse: %0d results outstanding, required 0", sb.size());
            end
            end_done = 1'b1;
        end
    end

    initial begin
        last_exp = '0;
        total    = 0;
        bad      = 0;
        end_chk  = 1'b0;
        end_done = 1'b0;
        rst      = 1'b1;
        vld_in   = 1'b0;
        data_in  = '0;
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 8'd7, 8'd7, 8'd7, 8'd7);
        end
        @(posedge clk);
        #1;
        rst    = 1'b1;
        vld_in = 1'b0;

        frame(8'd2, 8'd0, 8'd1, 8'd0, 1'b0, 1'b0, pat(10'd2, 10'd0, 10'd1, 10'd0));
        frame(8'hFB, 8'h80, 8'h05, 8'h00, 1'b0, 1'b0, pat(10'd0, 10'd0, 10'd5, 10'd0));
        frame(8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, pat(10'd31, 10'd0, 10'd0, 10'd0));
        frame(8'd2, 8'd0, 8'd1, 8'd0, 1'b0, 1'b1, pat(10'd2, 10'd0, 10'd1, 10'd0));
        for (int n = 0; n < 9; n++) begin
            frame(8'd2, 8'd0, 8'd1, 8'd0, 1'b0, 1'b0, pat(10'd2, 10'd0, 10'd1, 10'd0));
        end

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        vld_in = 1'b0;
        frame(8'd2, 8'd0, 8'd1, 8'd0, 1'b0, 1'b0, pat(10'd2, 10'd0, 10'd1, 10'd0));

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        end
        end_chk = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
